// File: rtl/usb1d_pkg.sv
// Shared definitions for the USB 1.1 device packet assembler.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package usb1d_pkg;

  // PID nibbles as sent on the wire (low nibble of the PID byte).
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;
  localparam logic [3:0] PID_NYET  = 4'b0110;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_DATA2 = 4'b0111;
  localparam logic [3:0] PID_MDATA = 4'b1111;

  // cmd_type encodings.
  localparam logic CMD_HS   = 1'b0;
  localparam logic CMD_DATA = 1'b1;

  // Assembler FSM; the encoding is exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PID  = 3'd1,
    ST_DATA = 3'd2,
    ST_CRC1 = 3'd3,
    ST_CRC2 = 3'd4
  } pa_state_t;

  // The PID byte carries the nibble in the low half and its complement above.
  function automatic logic [7:0] pid_byte(input logic [3:0] p);
    return {~p, p};
  endfunction

endpackage

// File: rtl/usb1d_crc16.sv
// Byte-wide CRC16-USB step (poly 0x8005 reflected = 0xA001, LSB first).
// Latency: combinational; caller owns the state register.
// Backpressure: none; caller only advances the register on accepted bytes.
// Ports: crc_in (current register), data (byte to fold in), crc_out (next register).
module usb1d_crc16 (
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  logic [15:0] c;

  always_comb begin
    c = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/usb1d_pa_gen.sv
// USB 1.1 device packet assembler: PID, FIFO payload and optional CRC16 onto UTMI TX.
// Latency: PID byte is presented the cycle after command capture; one byte per tx_ready.
// Backpressure: tx_ready stalls with tx_data held; FIFO empty mid-payload aborts the packet.
// Ports: cmd_* command handshake (cmd_ready only in IDLE); tx_* UTMI byte interface;
//        fifo_* show-ahead TX FIFO; pkt_done/pkt_err one-cycle status; state debug.
module usb1d_pa_gen
  import usb1d_pkg::*;
#(
  parameter int MAX_PKT_SIZE = 64,
  parameter int CNT_W        = $clog2(MAX_PKT_SIZE + 1),
  parameter bit CRC_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_type,
  input  logic [3:0]       cmd_pid,
  input  logic [CNT_W-1:0] cmd_len,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_valid_last,
  output logic             tx_first,
  input  logic             tx_ready,
  input  logic [7:0]       fifo_data,
  input  logic             fifo_empty,
  output logic             fifo_re,
  output logic             pkt_done,
  output logic             pkt_err,
  output logic [2:0]       state
);

  localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MAX_PKT_SIZE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  pa_state_t        st_q, st_d;
  logic [7:0]       pid_q;
  logic             data_q;
  logic [CNT_W-1:0] rem_q;
  logic [15:0]      crc_q, crc_nxt, crc_tx;
  logic             ready_en;
  logic             fire, clamp, data_acc;
  logic [CNT_W-1:0] len_eff;

  // ready_en keeps cmd_ready low while reset is asserted, so every output is 0 in reset.
  assign cmd_ready = ready_en & (st_q == ST_IDLE);
  assign fire      = cmd_valid & cmd_ready;
  // Handshakes carry no payload, so their length field is never clamped or flagged.
  assign clamp     = (cmd_type == CMD_DATA) && (cmd_len > MAX_LEN);
  assign len_eff   = clamp ? MAX_LEN : cmd_len;
  assign data_acc  = (st_q == ST_DATA) & ~fifo_empty & tx_ready;
  assign crc_tx    = ~crc_q;
  assign state     = st_q;

  usb1d_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (fifo_data),
    .crc_out (crc_nxt)
  );

  always_comb begin
    st_d          = st_q;
    tx_data       = 8'h00;
    tx_valid      = 1'b0;
    tx_valid_last = 1'b0;
    tx_first      = 1'b0;
    fifo_re       = 1'b0;
    pkt_done      = 1'b0;
    pkt_err       = 1'b0;
    case (st_q)
      ST_IDLE: begin
        if (fire) begin
          st_d    = ST_PID;
          pkt_err = clamp;
        end
      end
      ST_PID: begin
        tx_data       = pid_q;
        tx_valid      = 1'b1;
        tx_first      = 1'b1;
        tx_valid_last = !data_q || (rem_q == '0 && !CRC_EN);
        if (tx_ready) begin
          if (!data_q) begin
            st_d     = ST_IDLE;
            pkt_done = 1'b1;
          end else if (rem_q != '0) begin
            st_d = ST_DATA;
          end else if (CRC_EN) begin
            st_d = ST_CRC1;
          end else begin
            st_d     = ST_IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      ST_DATA: begin
        tx_data       = fifo_data;
        tx_valid      = !fifo_empty;
        tx_valid_last = (rem_q == ONE) && !CRC_EN;
        fifo_re       = data_acc;
        if (fifo_empty) begin
          // Underrun: leave the packet unterminated so the PHY aborts it.
          st_d    = ST_IDLE;
          pkt_err = 1'b1;
        end else if (tx_ready && rem_q == ONE) begin
          if (CRC_EN) begin
            st_d = ST_CRC1;
          end else begin
            st_d     = ST_IDLE;
            pkt_done = 1'b1;
          end
        end
      end
      ST_CRC1: begin
        tx_data  = crc_tx[7:0];
        tx_valid = 1'b1;
        if (tx_ready) st_d = ST_CRC2;
      end
      ST_CRC2: begin
        tx_data       = crc_tx[15:8];
        tx_valid      = 1'b1;
        tx_valid_last = 1'b1;
        if (tx_ready) begin
          st_d     = ST_IDLE;
          pkt_done = 1'b1;
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q     <= ST_IDLE;
      pid_q    <= 8'h00;
      data_q   <= 1'b0;
      rem_q    <= '0;
      crc_q    <= 16'hFFFF;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      st_q     <= st_d;
      if (fire) begin
        pid_q  <= pid_byte(cmd_pid);
        data_q <= cmd_type;
        rem_q  <= (cmd_type == CMD_DATA) ? len_eff : '0;
        crc_q  <= 16'hFFFF;
      end else if (data_acc) begin
        rem_q <= rem_q - ONE;
        crc_q <= crc_nxt;
      end
    end
  end

endmodule
